// File: rtl/team_06_i2s_pkg.sv
// Shared types and defaults for the team_06 I2S transmit path.
// Sample conversion helper maps unsigned midscale samples onto two's complement.
package team_06_i2s_pkg;

  localparam int unsigned DefClkDiv  = 4;
  localparam int unsigned DefSampleW = 8;
  localparam int unsigned DefSlotW   = 16;

  typedef enum logic {
    IDLE,
    RUN
  } state_e;

  // Inverting the MSB turns offset-binary (midscale = 2^(width-1)) into two's complement.
  function automatic logic [31:0] msb_invert(input logic [31:0] value, input int unsigned width);
    return value ^ (32'd1 << (width - 1));
  endfunction

endpackage

// File: rtl/team_06_i2s_bclk_gen.sv
// Bit clock divider: bclk toggles every CLK_DIV clk cycles while enabled.
// fall is high for the clk cycle whose closing edge drives bclk from 1 to 0.
module team_06_i2s_bclk_gen #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic bclk,
  output logic fall
);

  localparam int unsigned DivW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DivW-1:0] DivLast = DivW'(CLK_DIV - 1);

  logic [DivW-1:0] div_cnt_q;
  logic            bclk_q;
  logic            div_wrap;

  assign div_wrap = en && (div_cnt_q == DivLast);
  assign fall     = div_wrap && bclk_q;
  assign bclk     = bclk_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      div_cnt_q <= '0;
      bclk_q    <= 1'b0;
    end else if (!en) begin
      div_cnt_q <= '0;
      bclk_q    <= 1'b0;
    end else if (div_wrap) begin
      div_cnt_q <= '0;
      bclk_q    <= ~bclk_q;
    end else begin
      div_cnt_q <= div_cnt_q + DivW'(1);
    end
  end

endmodule

// File: rtl/team_06_i2s_tx.sv
// I2S transmitter: one-deep holding register feeding a frame register that is sent
// MSB-first, one bclk after each lrclk change, in both left and right slots.
module team_06_i2s_tx
  import team_06_i2s_pkg::*;
#(
  parameter int unsigned CLK_DIV  = DefClkDiv,
  parameter int unsigned SAMPLE_W = DefSampleW,
  parameter int unsigned SLOT_W   = DefSlotW
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [SAMPLE_W-1:0] sample_in,
  input  logic                sample_valid,
  output logic                sample_ready,
  output logic                bclk,
  output logic                lrclk,
  output logic                sd,
  output logic                underrun
);

  localparam int unsigned PW = $clog2(SLOT_W);
  localparam logic [PW-1:0] PLast = PW'(SLOT_W - 1);
  localparam logic [PW-1:0] PData = PW'(SAMPLE_W);

  state_e              state_q;
  logic                hold_full_q;
  logic [SAMPLE_W-1:0] hold_q;
  logic [SAMPLE_W-1:0] frame_q;
  logic [SAMPLE_W-1:0] shift_q;
  logic [PW-1:0]       p_q;
  logic                lrclk_q;
  logic                sd_q;
  logic                underrun_q;

  logic                bclk_en;
  logic                fall;
  logic                accept;
  logic                slot_wrap;
  logic                frame_start;
  logic [PW-1:0]       p_nxt;
  logic [SAMPLE_W-1:0] sample_conv;

  assign bclk_en     = (state_q == RUN);
  assign accept      = sample_valid && !hold_full_q;
  assign slot_wrap   = (p_q == PLast);
  assign p_nxt       = slot_wrap ? '0 : p_q + PW'(1);
  assign frame_start = fall && slot_wrap && lrclk_q;
  assign sample_conv = SAMPLE_W'(msb_invert(32'(sample_in), SAMPLE_W));

  assign sample_ready = !hold_full_q;
  assign lrclk        = lrclk_q;
  assign sd           = sd_q;
  assign underrun     = underrun_q;

  team_06_i2s_bclk_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_bclk_gen (
    .clk (clk),
    .rst (rst),
    .en  (bclk_en),
    .bclk(bclk),
    .fall(fall)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      hold_full_q <= 1'b0;
      hold_q      <= '0;
      frame_q     <= '0;
      shift_q     <= '0;
      p_q         <= '0;
      lrclk_q     <= 1'b1;
      sd_q        <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      underrun_q <= 1'b0;
      // Accept and load are exclusive: accept needs holding empty, load needs it full.
      if (accept) begin
        hold_q      <= sample_conv;
        hold_full_q <= 1'b1;
      end
      case (state_q)
        IDLE: begin
          if (hold_full_q) begin
            state_q     <= RUN;
            lrclk_q     <= 1'b0;
            frame_q     <= hold_q;
            shift_q     <= hold_q;
            hold_full_q <= 1'b0;
            p_q         <= '0;
            sd_q        <= 1'b0;
          end
        end
        RUN: begin
          if (fall) begin
            p_q <= p_nxt;
            if (slot_wrap) begin
              lrclk_q <= ~lrclk_q;
              sd_q    <= 1'b0;
              if (frame_start && hold_full_q) begin
                frame_q     <= hold_q;
                shift_q     <= hold_q;
                hold_full_q <= 1'b0;
              end else begin
                // Right slot, or a starved frame: resend the current frame word.
                shift_q    <= frame_q;
                underrun_q <= frame_start;
              end
            end else if (p_nxt <= PData) begin
              sd_q    <= shift_q[SAMPLE_W-1];
              shift_q <= shift_q << 1;
            end else begin
              sd_q <= 1'b0;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_team_06_i2s_tx.sv
// Scenario bench for team_06_i2s_tx: decodes I2S frames on bclk rises and compares them
// against expected frame words queued as samples are offered.
module tb_team_06_i2s_tx;

  localparam int unsigned CLK_DIV  = 4;
  localparam int unsigned SAMPLE_W = 8;
  localparam int unsigned SLOT_W   = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] sample_in = 8'h00;
  logic       sample_valid = 1'b0;
  logic       sample_ready;
  logic       bclk;
  logic       lrclk;
  logic       sd;
  logic       underrun;

  team_06_i2s_tx #(
    .CLK_DIV (CLK_DIV),
    .SAMPLE_W(SAMPLE_W),
    .SLOT_W  (SLOT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .sample_in   (sample_in),
    .sample_valid(sample_valid),
    .sample_ready(sample_ready),
    .bclk        (bclk),
    .lrclk       (lrclk),
    .sd          (sd),
    .underrun    (underrun)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] l;
    logic [7:0] r;
    logic       pad;
  } frame_t;

  frame_t     got_q[$];
  logic [7:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int ur_cycles = 0;
  int ur_long = 0;
  int ur_misaligned = 0;

  // Frame decoder: bit k of a slot is sd at the k-th bclk rise after lrclk changes.
  initial begin : mon
    logic [SLOT_W-1:0] bits;
    int                k;
    logic              slot_lr, prev_bclk, have_left, pad, left_pad;
    logic [7:0]        w, left_w;
    k = 0; slot_lr = 1'b1; prev_bclk = 1'b0; have_left = 1'b0; bits = '0;
    left_w = 8'h00; left_pad = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        k = 0; slot_lr = 1'b1; prev_bclk = 1'b0; have_left = 1'b0;
      end else begin
        if (bclk === 1'b1 && prev_bclk === 1'b0) begin
          if (lrclk !== slot_lr) begin
            if (k == SLOT_W) begin
              w   = bits[14:7];
              pad = bits[15] | (|bits[6:0]);
              if (slot_lr === 1'b0) begin
                left_w = w; left_pad = pad; have_left = 1'b1;
              end else if (have_left) begin
                got_q.push_back({left_w, w, left_pad | pad});
                have_left = 1'b0;
              end
            end else begin
              have_left = 1'b0;
            end
            k = 0;
            slot_lr = lrclk;
          end
          bits = {bits[SLOT_W-2:0], sd};
          k++;
        end
        prev_bclk = bclk;
      end
    end
  end

  initial begin : ur_mon
    logic prev_ur, prev_lr;
    prev_ur = 1'b0; prev_lr = 1'b1;
    forever begin
      @(negedge clk);
      if (underrun === 1'b1) begin
        ur_cycles++;
        if (prev_ur === 1'b1) ur_long++;
        if (!(lrclk === 1'b0 && prev_lr === 1'b1)) ur_misaligned++;
      end
      prev_ur = underrun;
      prev_lr = lrclk;
    end
  end

  task automatic apply_reset();
    rst = 1'b0;
    sample_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic release_reset();
    rst = 1'b1;
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic send(input logic [7:0] v);
    int n = 0;
    while (sample_ready !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (sample_ready !== 1'b1) begin
      errors++;
      $display("FAIL send_ready timeout: sample_ready=%b after %0d cycles, need 1", sample_ready, n);
    end else begin
      if (n > 0) #1;
      sample_in = v;
      sample_valid = 1'b1;
      @(posedge clk);
      #1;
      sample_valid = 1'b0;
    end
  endtask

  task automatic wait_got(input int n, input string name);
    int t = 0;
    while (got_q.size() < n && t < 3000) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (got_q.size() < n) begin
      errors++;
      $display("FAIL %s frame timeout: got %0d frames, need %0d", name, got_q.size(), n);
    end
  endtask

  task automatic wait_lr_low(input string name);
    int t = 0;
    while (lrclk !== 1'b0 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (lrclk !== 1'b0) begin
      errors++;
      $display("FAIL %s lrclk_low timeout: lrclk=%b, need 0", name, lrclk);
    end
  endtask

  task automatic test_reset();
    int   edges;
    logic prev;
    apply_reset();
    checks += 5;
    if (bclk !== 1'b0) begin errors++; $display("FAIL reset_bclk: got %b need 0", bclk); end
    if (lrclk !== 1'b1) begin errors++; $display("FAIL reset_lrclk: got %b need 1", lrclk); end
    if (sd !== 1'b0) begin errors++; $display("FAIL reset_sd: got %b need 0", sd); end
    if (sample_ready !== 1'b1) begin
      errors++; $display("FAIL reset_ready: got %b need 1", sample_ready);
    end
    if (underrun !== 1'b0) begin
      errors++; $display("FAIL reset_underrun: got %b need 0", underrun);
    end
    release_reset();
    edges = 0;
    prev = bclk;
    repeat (50) begin
      @(negedge clk);
      if (bclk !== prev) edges++;
      prev = bclk;
    end
    checks += 2;
    if (edges != 0) begin errors++; $display("FAIL idle_bclk_edges: got %0d need 0", edges); end
    if (lrclk !== 1'b1) begin errors++; $display("FAIL idle_lrclk: got %b need 1", lrclk); end
  endtask

  task automatic test_single();
    int n;
    logic [7:0] e;
    frame_t g;
    apply_reset();
    release_reset();
    exp_q.push_back(8'h45);
    send(8'hC5);
    wait_lr_low("single");
    n = 0;
    while (lrclk === 1'b0 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n != 128) begin errors++; $display("FAIL single_lrclk_low: got %0d clk need 128", n); end
    wait_got(1, "single");
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front();
      g = got_q.pop_front();
      checks += 3;
      if (g.l !== e) begin errors++; $display("FAIL single_left: got %h need %h", g.l, e); end
      if (g.r !== e) begin errors++; $display("FAIL single_right: got %h need %h", g.r, e); end
      if (g.pad !== 1'b0) begin errors++; $display("FAIL single_pad: got %b need 0", g.pad); end
    end
  endtask

  task automatic test_back_to_back();
    int base;
    logic [7:0] e;
    frame_t g;
    apply_reset();
    release_reset();
    base = ur_cycles;
    exp_q.push_back(8'h80);
    exp_q.push_back(8'h7F);
    send(8'h00);
    send(8'hFF);
    send(8'h80);  // keeps frame 3 fed so no underrun is due before frame 2 is decoded
    wait_got(2, "b2b");
    checks++;
    if (ur_cycles - base != 0) begin
      errors++; $display("FAIL b2b_underrun: got %0d pulses need 0", ur_cycles - base);
    end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front();
      g = got_q.pop_front();
      checks += 3;
      if (g.l !== e) begin errors++; $display("FAIL b2b_left: got %h need %h", g.l, e); end
      if (g.r !== e) begin errors++; $display("FAIL b2b_right: got %h need %h", g.r, e); end
      if (g.pad !== 1'b0) begin errors++; $display("FAIL b2b_pad: got %b need 0", g.pad); end
    end
  endtask

  task automatic test_underrun();
    int base, lbase, mbase;
    logic [7:0] e;
    frame_t g;
    apply_reset();
    release_reset();
    base = ur_cycles; lbase = ur_long; mbase = ur_misaligned;
    exp_q.push_back(8'h10);
    exp_q.push_back(8'h10);
    send(8'h90);
    wait_got(1, "underrun1");
    checks++;
    if (ur_cycles - base != 1) begin
      errors++; $display("FAIL ur_first: got %0d pulses need 1", ur_cycles - base);
    end
    wait_got(2, "underrun2");
    checks += 3;
    if (ur_cycles - base != 2) begin
      errors++; $display("FAIL ur_second: got %0d pulses need 2", ur_cycles - base);
    end
    if (ur_long - lbase != 0) begin
      errors++; $display("FAIL ur_width: got %0d long pulses need 0", ur_long - lbase);
    end
    if (ur_misaligned - mbase != 0) begin
      errors++; $display("FAIL ur_align: got %0d misaligned need 0", ur_misaligned - mbase);
    end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front();
      g = got_q.pop_front();
      checks += 2;
      if (g.l !== e) begin errors++; $display("FAIL ur_left: got %h need %h", g.l, e); end
      if (g.r !== e) begin errors++; $display("FAIL ur_right: got %h need %h", g.r, e); end
    end
  endtask

  task automatic test_collision();
    int base;
    logic [7:0] e;
    frame_t g;
    apply_reset();
    release_reset();
    base = ur_cycles;
    exp_q.push_back(8'hA1);
    exp_q.push_back(8'hA1);
    exp_q.push_back(8'hB3);
    send(8'h21);
    wait_lr_low("collision");
    // Frame start is 256 clk after the edge that first drove lrclk low.
    repeat (255) @(posedge clk);
    #1;
    checks++;
    if (sample_ready !== 1'b1) begin
      errors++; $display("FAIL coll_ready_pre: got %b need 1", sample_ready);
    end
    sample_in = 8'h33;
    sample_valid = 1'b1;
    @(posedge clk);
    #1;
    sample_valid = 1'b0;
    checks += 2;
    if (lrclk !== 1'b0) begin errors++; $display("FAIL coll_lrclk: got %b need 0", lrclk); end
    if (sample_ready !== 1'b0) begin
      errors++; $display("FAIL coll_ready_post: got %b need 0", sample_ready);
    end
    wait_got(1, "collision1");
    checks++;
    if (ur_cycles - base != 1) begin
      errors++; $display("FAIL coll_underrun: got %0d pulses need 1", ur_cycles - base);
    end
    wait_got(3, "collision3");
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front();
      g = got_q.pop_front();
      checks += 2;
      if (g.l !== e) begin errors++; $display("FAIL coll_left: got %h need %h", g.l, e); end
      if (g.r !== e) begin errors++; $display("FAIL coll_right: got %h need %h", g.r, e); end
    end
  endtask

  task automatic test_reset_mid();
    int n;
    logic [7:0] e;
    frame_t g;
    apply_reset();
    release_reset();
    send(8'h5A);
    wait_lr_low("midrst");
    // Right slot starts 128 clk in; p reaches 5 on the fall at +168.
    repeat (170) @(posedge clk);
    #1;
    checks++;
    if (lrclk !== 1'b1) begin errors++; $display("FAIL mid_in_right: lrclk %b need 1", lrclk); end
    rst = 1'b0;
    @(posedge clk);
    #1;
    checks += 5;
    if (bclk !== 1'b0) begin errors++; $display("FAIL mid_bclk: got %b need 0", bclk); end
    if (lrclk !== 1'b1) begin errors++; $display("FAIL mid_lrclk: got %b need 1", lrclk); end
    if (sd !== 1'b0) begin errors++; $display("FAIL mid_sd: got %b need 0", sd); end
    if (sample_ready !== 1'b1) begin
      errors++; $display("FAIL mid_ready: got %b need 1", sample_ready);
    end
    if (underrun !== 1'b0) begin errors++; $display("FAIL mid_underrun: got %b need 0", underrun); end
    release_reset();
    exp_q.push_back(8'h92);
    send(8'h12);
    wait_lr_low("restart");
    n = 0;
    while (lrclk === 1'b0 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n != 128) begin errors++; $display("FAIL restart_lrclk_low: got %0d clk need 128", n); end
    wait_got(1, "restart");
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front();
      g = got_q.pop_front();
      checks += 3;
      if (g.l !== e) begin errors++; $display("FAIL restart_left: got %h need %h", g.l, e); end
      if (g.r !== e) begin errors++; $display("FAIL restart_right: got %h need %h", g.r, e); end
      if (g.pad !== 1'b0) begin errors++; $display("FAIL restart_pad: got %b need 0", g.pad); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_underrun();
    test_collision();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
